// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the I/D-cache memory port arbiter.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking instead of fixed D-over-I priority.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2,
    ARB_RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    ARB_GRANT_I = 1'b0,
    ARB_GRANT_D = 1'b1
  } arb_grant_e;

  localparam int ARB_STATE_W = 2;

endpackage

// File: rtl/mem_port_arbiter_arb_grant_select.sv
// Combinational requester pick for the memory port arbiter.
// Fixed D-over-I priority, or round-robin on ties when MEM_ARB_ROUND_ROBIN_EN is defined.
module arb_grant_select
  import mem_port_arbiter_pkg::*;
(
  input  logic       ic_req,
  input  logic       dc_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  arb_grant_e last_grant,
`endif
  output logic       grant_valid,
  output arb_grant_e grant
);

  always_comb begin
    grant_valid = ic_req | dc_req;
    grant       = ARB_GRANT_D;
    if (ic_req && dc_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant = (last_grant == ARB_GRANT_D) ? ARB_GRANT_I : ARB_GRANT_D;
`else
      // The MEM-stage miss is older in program order than the IF-stage miss.
      grant = ARB_GRANT_D;
`endif
    end else if (ic_req) begin
      grant = ARB_GRANT_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the main-memory block port between the I-cache and D-cache controllers.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: D-cache wins ties).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ic_req,
  input  logic               ic_write,
  input  logic [ADDR_W-1:0]  ic_addr,
  input  logic [BLOCK_W-1:0] ic_wdata,
  output logic [BLOCK_W-1:0] ic_rdata,
  output logic               ic_ack,
  input  logic               dc_req,
  input  logic               dc_write,
  input  logic [ADDR_W-1:0]  dc_addr,
  input  logic [BLOCK_W-1:0] dc_wdata,
  output logic [BLOCK_W-1:0] dc_rdata,
  output logic               dc_ack,
  output logic               mem_enable_o,
  output logic               mem_write_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [BLOCK_W-1:0] mem_data_o,
  input  logic [BLOCK_W-1:0] mem_data_i,
  input  logic               mem_ack_i,
  output logic [ARB_STATE_W-1:0] state_dbg
);

  // Handshakes: a cache raises x_req with x_write/x_addr/x_wdata stable and keeps it high
  // until x_ack, a one-cycle pulse (x_rdata valid with it). Toward memory, mem_enable_o and
  // the command fields stay constant until the one-cycle mem_ack_i completes the transfer.

  arb_state_e state;
  logic       grant_valid;
  arb_grant_e grant_sel;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_grant_e last_grant;
`endif

  arb_grant_select u_grant_select (
    .ic_req      (ic_req),
    .dc_req      (dc_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_grant  (last_grant),
`endif
    .grant_valid (grant_valid),
    .grant       (grant_sel)
  );

  assign state_dbg = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ARB_IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      ic_rdata     <= '0;
      dc_rdata     <= '0;
      ic_ack       <= 1'b0;
      dc_ack       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant   <= ARB_GRANT_I;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_valid) begin
            mem_enable_o <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant   <= grant_sel;
`endif
            if (grant_sel == ARB_GRANT_D) begin
              mem_write_o <= dc_write;
              mem_addr_o  <= dc_addr;
              mem_data_o  <= dc_wdata;
              state       <= ARB_BUSY_D;
            end else begin
              mem_write_o <= ic_write;
              mem_addr_o  <= ic_addr;
              mem_data_o  <= ic_wdata;
              state       <= ARB_BUSY_I;
            end
          end
        end

        ARB_BUSY_I, ARB_BUSY_D: begin
          // The latched command is the transaction; req may already be low here.
          if (mem_ack_i) begin
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            state        <= ARB_RESP;
            if (state == ARB_BUSY_D) begin
              dc_ack <= 1'b1;
              if (!mem_write_o) dc_rdata <= mem_data_i;
            end else begin
              ic_ack <= 1'b1;
              if (!mem_write_o) ic_rdata <= mem_data_i;
            end
          end
        end

        ARB_RESP: begin
          // No grant here: the acked requester gets this cycle to drop its req.
          ic_ack <= 1'b0;
          dc_ack <= 1'b0;
          state  <= ARB_IDLE;
        end

        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single read, tie-break, held command,
// requester drop, spurious memory ack, and asynchronous reset mid-transaction.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 32;
  localparam int BLOCK_W = 256;

  logic               clock;
  logic               reset;
  logic               ic_req, ic_write, dc_req, dc_write;
  logic [ADDR_W-1:0]  ic_addr, dc_addr;
  logic [BLOCK_W-1:0] ic_wdata, dc_wdata, ic_rdata, dc_rdata;
  logic               ic_ack, dc_ack;
  logic               mem_enable_o, mem_write_o, mem_ack_i;
  logic [ADDR_W-1:0]  mem_addr_o;
  logic [BLOCK_W-1:0] mem_data_o, mem_data_i;
  logic [1:0]         state_dbg;

  int total = 0;
  int bad   = 0;

  logic [BLOCK_W-1:0] p_aa, p_55, p_12, p_3c, p_c3, p_77, p_88, p_ff;
  logic [BLOCK_W-1:0] exp_ic_rdata, exp_dc_rdata;
  logic               first_is_d;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .ic_req       (ic_req),
    .ic_write     (ic_write),
    .ic_addr      (ic_addr),
    .ic_wdata     (ic_wdata),
    .ic_rdata     (ic_rdata),
    .ic_ack       (ic_ack),
    .dc_req       (dc_req),
    .dc_write     (dc_write),
    .dc_addr      (dc_addr),
    .dc_wdata     (dc_wdata),
    .dc_rdata     (dc_rdata),
    .dc_ack       (dc_ack),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [BLOCK_W-1:0] obs, input logic [BLOCK_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // memory returns its one-cycle ack; caller sits in the RESP cycle afterwards
  task automatic mem_ack(input logic [BLOCK_W-1:0] data);
    mem_ack_i  = 1'b1;
    mem_data_i = data;
    step();
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_en"},  256'(mem_enable_o), 256'(1'b0));
    chk({tag, "_wr"},  256'(mem_write_o),  256'(1'b0));
    chk({tag, "_iak"}, 256'(ic_ack),       256'(1'b0));
    chk({tag, "_dak"}, 256'(dc_ack),       256'(1'b0));
  endtask

  initial begin
    p_aa = {32{8'hAA}};
    p_55 = {32{8'h55}};
    p_12 = {32{8'h12}};
    p_3c = {32{8'h3C}};
    p_c3 = {32{8'hC3}};
    p_77 = {32{8'h77}};
    p_88 = {32{8'h88}};
    p_ff = {32{8'hFF}};

    reset = 1'b0;
    ic_req = 1'b0; ic_write = 1'b0; ic_addr = '0; ic_wdata = '0;
    dc_req = 1'b0; dc_write = 1'b0; dc_addr = '0; dc_wdata = '0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    repeat (2) step();

    // reset state
    chk_idle_outputs("rst");
    chk("rst_addr",  256'(mem_addr_o), 256'(32'h0));
    chk("rst_data",  mem_data_o, '0);
    chk("rst_irdat", ic_rdata, '0);
    chk("rst_drdat", dc_rdata, '0);
    chk("rst_state", 256'(state_dbg), 256'(2'd0));
    reset = 1'b1;
    step();
    chk("post_rst_state", 256'(state_dbg), 256'(2'd0));

    // single I read of 0x40, memory acks 3 cycles after enable
    ic_req = 1'b1; ic_write = 1'b0; ic_addr = 32'h40;
    step();
    chk("t1_en",    256'(mem_enable_o), 256'(1'b1));
    chk("t1_wr",    256'(mem_write_o),  256'(1'b0));
    chk("t1_addr",  256'(mem_addr_o),   256'(32'h40));
    chk("t1_state", 256'(state_dbg),    256'(2'd1));
    step();
    step();
    chk("t1_hold_en", 256'(mem_enable_o), 256'(1'b1));
    chk("t1_no_ack",  256'(ic_ack),       256'(1'b0));
    mem_ack(p_aa);
    chk("t1_iack",  256'(ic_ack),       256'(1'b1));
    chk("t1_irdat", ic_rdata,           p_aa);
    chk("t1_dack",  256'(dc_ack),       256'(1'b0));
    chk("t1_en_dn", 256'(mem_enable_o), 256'(1'b0));
    chk("t1_resp",  256'(state_dbg),    256'(2'd3));
    ic_req = 1'b0;
    step();
    chk("t1_iack_1cyc", 256'(ic_ack),    256'(1'b0));
    chk("t1_idle",      256'(state_dbg), 256'(2'd0));
    exp_ic_rdata = p_aa;
    exp_dc_rdata = '0;

    // simultaneous: I read 0x100, D write 0x80 -> D first (last grant was I in either build)
    ic_req = 1'b1; ic_write = 1'b0; ic_addr = 32'h100;
    dc_req = 1'b1; dc_write = 1'b1; dc_addr = 32'h80; dc_wdata = p_55;
    step();
    chk("t2_state", 256'(state_dbg),   256'(2'd2));
    chk("t2_wr",    256'(mem_write_o), 256'(1'b1));
    chk("t2_addr",  256'(mem_addr_o),  256'(32'h80));
    chk("t2_data",  mem_data_o,        p_55);
    // D changes its command mid-transfer; the port must not follow
    dc_addr = 32'h999; dc_wdata = '0;
    step();
    chk("t2_hold_addr", 256'(mem_addr_o), 256'(32'h80));
    chk("t2_hold_data", mem_data_o,       p_55);
    mem_ack(p_12);
    chk("t2_dack",  256'(dc_ack),       256'(1'b1));
    chk("t2_iack",  256'(ic_ack),       256'(1'b0));
    chk("t2_drdat", dc_rdata,           exp_dc_rdata);
    chk("t2_en_dn", 256'(mem_enable_o), 256'(1'b0));
    dc_req = 1'b0;
    step();
    chk("t2_gap_en",  256'(mem_enable_o), 256'(1'b0));
    chk("t2_gap_dak", 256'(dc_ack),       256'(1'b0));
    step();
    chk("t2_i_en",    256'(mem_enable_o), 256'(1'b1));
    chk("t2_i_state", 256'(state_dbg),    256'(2'd1));
    chk("t2_i_addr",  256'(mem_addr_o),   256'(32'h100));
    chk("t2_i_wr",    256'(mem_write_o),  256'(1'b0));
    mem_ack(p_3c);
    exp_ic_rdata = p_3c;
    chk("t2_i_ack",   256'(ic_ack), 256'(1'b1));
    chk("t2_i_rdat",  ic_rdata,     exp_ic_rdata);
    chk("t2_i_dak",   256'(dc_ack), 256'(1'b0));
    ic_req = 1'b0;
    step();

    // D read 0x300; D drops req during BUSY, transfer still completes and acks
    dc_req = 1'b1; dc_write = 1'b0; dc_addr = 32'h300;
    step();
    chk("t3_state", 256'(state_dbg),  256'(2'd2));
    chk("t3_addr",  256'(mem_addr_o), 256'(32'h300));
    dc_req = 1'b0;
    step();
    chk("t3_hold_en", 256'(mem_enable_o), 256'(1'b1));
    mem_ack(p_c3);
    exp_dc_rdata = p_c3;
    chk("t3_dack",  256'(dc_ack), 256'(1'b1));
    chk("t3_drdat", dc_rdata,     exp_dc_rdata);
    chk("t3_irdat", ic_rdata,     exp_ic_rdata);
    step();

    // simultaneous after a D grant: I read 0x200 vs D write 0x400
`ifdef MEM_ARB_ROUND_ROBIN_EN
    first_is_d = 1'b0;
`else
    first_is_d = 1'b1;
`endif
    ic_req = 1'b1; ic_write = 1'b0; ic_addr = 32'h200;
    dc_req = 1'b1; dc_write = 1'b1; dc_addr = 32'h400; dc_wdata = p_55;
    step();
    chk("t4_first_state", 256'(state_dbg),  first_is_d ? 256'(2'd2) : 256'(2'd1));
    chk("t4_first_addr",  256'(mem_addr_o), first_is_d ? 256'(32'h400) : 256'(32'h200));
    mem_ack(p_77);
    if (!first_is_d) exp_ic_rdata = p_77;
    chk("t4_first_dak", 256'(dc_ack), 256'(first_is_d));
    chk("t4_first_iak", 256'(ic_ack), 256'(!first_is_d));
    if (first_is_d) dc_req = 1'b0; else ic_req = 1'b0;
    step();
    step();
    chk("t4_second_state", 256'(state_dbg),  first_is_d ? 256'(2'd1) : 256'(2'd2));
    chk("t4_second_addr",  256'(mem_addr_o), first_is_d ? 256'(32'h200) : 256'(32'h400));
    mem_ack(p_88);
    if (first_is_d) exp_ic_rdata = p_88;
    chk("t4_irdat", ic_rdata, exp_ic_rdata);
    chk("t4_drdat", dc_rdata, exp_dc_rdata);
    ic_req = 1'b0; dc_req = 1'b0;
    step();

    // spurious memory ack while idle
    mem_ack_i = 1'b1; mem_data_i = p_ff;
    step();
    step();
    mem_ack_i = 1'b0; mem_data_i = '0;
    chk_idle_outputs("t5");
    chk("t5_state", 256'(state_dbg), 256'(2'd0));
    chk("t5_irdat", ic_rdata, exp_ic_rdata);
    chk("t5_drdat", dc_rdata, exp_dc_rdata);
    step();
    chk("t5_late_iak", 256'(ic_ack), 256'(1'b0));
    chk("t5_late_dak", 256'(dc_ack), 256'(1'b0));

    // asynchronous reset in BUSY_I
    ic_req = 1'b1; ic_write = 1'b1; ic_addr = 32'h500; ic_wdata = p_aa;
    step();
    chk("t6_busy", 256'(state_dbg), 256'(2'd1));
    #2;
    reset = 1'b0;
    #1;
    chk_idle_outputs("t6_rst");
    chk("t6_addr",  256'(mem_addr_o), 256'(32'h0));
    chk("t6_data",  mem_data_o, '0);
    chk("t6_irdat", ic_rdata, '0);
    chk("t6_state", 256'(state_dbg), 256'(2'd0));
    ic_req = 1'b0;
    step();
    reset = 1'b1;
    mem_ack_i = 1'b1; mem_data_i = p_ff;
    step();
    mem_ack_i = 1'b0; mem_data_i = '0;
    chk("t6_no_stale_iak", 256'(ic_ack),       256'(1'b0));
    chk("t6_no_en",        256'(mem_enable_o), 256'(1'b0));
    step();
    chk("t6_no_stale_iak2", 256'(ic_ack), 256'(1'b0));
    chk("t6_irdat_clean",   ic_rdata,     '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
